// File: rtl/generic_sram_line_en_dualport_pipe.sv
// True-dual-port line SRAM with per-port read pipeline, write-write priority and cross-port bypass.
// Optional macro SRAM_LINE_PARITY_EN adds an even-parity bit per line and a per-port read parity error.
module generic_sram_line_en_dualport_pipe #(
    parameter int unsigned MEM_ADDR_BITS = 10,
    parameter int unsigned MEM_DATA_BITS = 32,
    parameter int unsigned READ_LATENCY  = 1,
    parameter int unsigned BYPASS_EN     = 1
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_req_a,
    input  logic                     i_write_en_a,
    input  logic [MEM_ADDR_BITS-1:0] i_addr_a,
    input  logic [MEM_DATA_BITS-1:0] i_write_data_a,
    output logic [MEM_DATA_BITS-1:0] o_read_data_a,
    output logic                     o_rvalid_a,
    input  logic                     i_req_b,
    input  logic                     i_write_en_b,
    input  logic [MEM_ADDR_BITS-1:0] i_addr_b,
    input  logic [MEM_DATA_BITS-1:0] i_write_data_b,
    output logic [MEM_DATA_BITS-1:0] o_read_data_b,
    output logic                     o_rvalid_b,
    output logic                     o_collision,
    output logic                     o_parity_err_a,
    output logic                     o_parity_err_b
);

    localparam int unsigned DEPTH = 2 ** MEM_ADDR_BITS;
    localparam int unsigned DW    = MEM_DATA_BITS;
`ifdef SRAM_LINE_PARITY_EN
    localparam int unsigned ARRAY_W = DW + 1;
`else
    localparam int unsigned ARRAY_W = DW;
`endif

    if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
        $error("READ_LATENCY must be within 1..4");
    end

    logic [ARRAY_W-1:0] mem [DEPTH];

    logic               rd_a, rd_b, wr_a, wr_b;
    logic               same_addr, coll_c;
    logic               byp_a, byp_b;
    logic [ARRAY_W-1:0] wline_a, wline_b, rline_a, rline_b;
    logic [DW-1:0]      rsel_a, rsel_b;
    logic               rerr_a, rerr_b;

    logic [DW-1:0]      pd_a [READ_LATENCY];
    logic [DW-1:0]      pd_b [READ_LATENCY];
    logic               pv_a [READ_LATENCY];
    logic               pv_b [READ_LATENCY];
    logic               pe_a [READ_LATENCY];
    logic               pe_b [READ_LATENCY];

    // Request decode, cross-port hazard detection and stage-1 read data selection.
    always_comb begin
        rd_a      = i_req_a & ~i_write_en_a & ~i_rst;
        rd_b      = i_req_b & ~i_write_en_b & ~i_rst;
        wr_a      = i_req_a & i_write_en_a & ~i_rst;
        wr_b      = i_req_b & i_write_en_b & ~i_rst;
        same_addr = (i_addr_a == i_addr_b);
        coll_c    = wr_a & wr_b & same_addr;
        byp_a     = (BYPASS_EN != 0) & wr_b & same_addr;
        byp_b     = (BYPASS_EN != 0) & wr_a & same_addr;
`ifdef SRAM_LINE_PARITY_EN
        wline_a   = {^i_write_data_a, i_write_data_a};
        wline_b   = {^i_write_data_b, i_write_data_b};
`else
        wline_a   = i_write_data_a;
        wline_b   = i_write_data_b;
`endif
        rline_a   = mem[i_addr_a];
        rline_b   = mem[i_addr_b];
        rsel_a    = byp_a ? i_write_data_b : rline_a[DW-1:0];
        rsel_b    = byp_b ? i_write_data_a : rline_b[DW-1:0];
`ifdef SRAM_LINE_PARITY_EN
        rerr_a    = (^rline_a) & ~byp_a;
        rerr_b    = (^rline_b) & ~byp_b;
`else
        rerr_a    = 1'b0;
        rerr_b    = 1'b0;
`endif
    end

    // Array writes; on a same-address double write port A wins.
    always_ff @(posedge i_clk) begin
        if (wr_a) begin
            mem[i_addr_a] <= wline_a;
        end
        if (wr_b && !coll_c) begin
            mem[i_addr_b] <= wline_b;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pv_a[0]     <= 1'b0;
            pv_b[0]     <= 1'b0;
            pe_a[0]     <= 1'b0;
            pe_b[0]     <= 1'b0;
            pd_a[0]     <= '0;
            pd_b[0]     <= '0;
            o_collision <= 1'b0;
        end else begin
            pv_a[0]     <= rd_a;
            pv_b[0]     <= rd_b;
            pe_a[0]     <= rd_a & rerr_a;
            pe_b[0]     <= rd_b & rerr_b;
            o_collision <= coll_c;
            if (rd_a) begin
                pd_a[0] <= rsel_a;
            end
            if (rd_b) begin
                pd_b[0] <= rsel_b;
            end
        end
    end

    // Retiming stages: data only advances with a valid so the output holds its last read.
    for (genvar k = 1; k < READ_LATENCY; k++) begin : g_stage
        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                pv_a[k] <= 1'b0;
                pv_b[k] <= 1'b0;
                pe_a[k] <= 1'b0;
                pe_b[k] <= 1'b0;
                pd_a[k] <= '0;
                pd_b[k] <= '0;
            end else begin
                pv_a[k] <= pv_a[k-1];
                pv_b[k] <= pv_b[k-1];
                pe_a[k] <= pe_a[k-1];
                pe_b[k] <= pe_b[k-1];
                if (pv_a[k-1]) begin
                    pd_a[k] <= pd_a[k-1];
                end
                if (pv_b[k-1]) begin
                    pd_b[k] <= pd_b[k-1];
                end
            end
        end
    end

    assign o_rvalid_a     = pv_a[READ_LATENCY-1];
    assign o_rvalid_b     = pv_b[READ_LATENCY-1];
    assign o_read_data_a  = pd_a[READ_LATENCY-1];
    assign o_read_data_b  = pd_b[READ_LATENCY-1];
    assign o_parity_err_a = pe_a[READ_LATENCY-1];
    assign o_parity_err_b = pe_b[READ_LATENCY-1];

endmodule

// File: tb/tb_generic_sram_line_en_dualport_pipe.sv
// Scoreboard bench: two instances (latency 3 write-first, latency 4 read-first) share one stimulus stream.
module tb_generic_sram_line_en_dualport_pipe;

    localparam int unsigned AW = 10;
    localparam int unsigned DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_a, we_a, req_b, we_b;
    logic [AW-1:0] addr_a, addr_b;
    logic [DW-1:0] wd_a, wd_b;

    logic [DW-1:0] rd3_a, rd3_b, rd4_a, rd4_b;
    logic          rv3_a, rv3_b, rv4_a, rv4_b;
    logic          coll3, coll4, pe3_a, pe3_b, pe4_a, pe4_b;

    always #5 clk = ~clk;

    generic_sram_line_en_dualport_pipe #(
        .MEM_ADDR_BITS(AW), .MEM_DATA_BITS(DW), .READ_LATENCY(3), .BYPASS_EN(1)
    ) dut3 (
        .i_clk(clk), .i_rst(rst),
        .i_req_a(req_a), .i_write_en_a(we_a), .i_addr_a(addr_a), .i_write_data_a(wd_a),
        .o_read_data_a(rd3_a), .o_rvalid_a(rv3_a),
        .i_req_b(req_b), .i_write_en_b(we_b), .i_addr_b(addr_b), .i_write_data_b(wd_b),
        .o_read_data_b(rd3_b), .o_rvalid_b(rv3_b),
        .o_collision(coll3), .o_parity_err_a(pe3_a), .o_parity_err_b(pe3_b)
    );

    generic_sram_line_en_dualport_pipe #(
        .MEM_ADDR_BITS(AW), .MEM_DATA_BITS(DW), .READ_LATENCY(4), .BYPASS_EN(0)
    ) dut4 (
        .i_clk(clk), .i_rst(rst),
        .i_req_a(req_a), .i_write_en_a(we_a), .i_addr_a(addr_a), .i_write_data_a(wd_a),
        .o_read_data_a(rd4_a), .o_rvalid_a(rv4_a),
        .i_req_b(req_b), .i_write_en_b(we_b), .i_addr_b(addr_b), .i_write_data_b(wd_b),
        .o_read_data_b(rd4_b), .o_rvalid_b(rv4_b),
        .o_collision(coll4), .o_parity_err_a(pe4_a), .o_parity_err_b(pe4_b)
    );

    typedef struct {
        logic [DW-1:0] data;
        logic          perr;
        int            cyc;
    } item_t;

    // Stream ids: 0 = dut3.A, 1 = dut3.B, 2 = dut4.A, 3 = dut4.B
    item_t         sbq   [4][$];
    int            collq [2][$];
    logic [DW-1:0] last_exp [4];
    int            checks   = 0;
    int            failures = 0;
    int            cyc      = 0;
    logic          rst_q    = 1'b0;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst;
    end

    task automatic chk_port(input int id, input logic v, input logic [DW-1:0] d, input logic pe);
        item_t it;
        if (rst_q) last_exp[id] = '0;
        if (v) begin
            checks++;
            if (sbq[id].size() == 0) begin
                failures++;
                $display("FAIL unexpected_rvalid stream=%0d cyc=%0d data=%h", id, cyc, d);
            end else begin
                it = sbq[id].pop_front();
                if (d !== it.data || pe !== it.perr || cyc != it.cyc) begin
                    failures++;
                    $display("FAIL read stream=%0d got data=%h perr=%b cyc=%0d want data=%h perr=%b cyc=%0d",
                             id, d, pe, cyc, it.data, it.perr, it.cyc);
                end
                last_exp[id] = it.data;
            end
        end else begin
            checks++;
            if (d !== last_exp[id] || pe !== 1'b0) begin
                failures++;
                $display("FAIL hold stream=%0d cyc=%0d got data=%h perr=%b want data=%h perr=0",
                         id, cyc, d, pe, last_exp[id]);
            end
            if (sbq[id].size() != 0 && sbq[id][0].cyc <= cyc) begin
                it = sbq[id].pop_front();
                checks++;
                failures++;
                $display("FAIL missing_rvalid stream=%0d cyc=%0d want data=%h at cyc=%0d",
                         id, cyc, it.data, it.cyc);
            end
        end
    endtask

    task automatic chk_coll(input int d, input logic c);
        logic e;
        while (collq[d].size() != 0 && collq[d][0] < cyc) void'(collq[d].pop_front());
        e = (collq[d].size() != 0 && collq[d][0] == cyc);
        checks++;
        if (c !== e) begin
            failures++;
            $display("FAIL collision dut=%0d cyc=%0d got=%b want=%b", d, cyc, c, e);
        end
        if (e) void'(collq[d].pop_front());
    endtask

    // Monitor: compares every presented output against the scoreboard.
    always @(negedge clk) begin
        if (cyc > 0) begin
            chk_port(0, rv3_a, rd3_a, pe3_a);
            chk_port(1, rv3_b, rd3_b, pe3_b);
            chk_port(2, rv4_a, rd4_a, pe4_a);
            chk_port(3, rv4_b, rd4_b, pe4_b);
            chk_coll(0, coll3);
            chk_coll(1, coll4);
        end
    end

    task automatic expect_rd(input int dut, input int port, input logic [DW-1:0] data,
                             input logic perr, input int n);
        item_t it;
        it.data = data;
        it.perr = perr;
        it.cyc  = n + ((dut == 0) ? 3 : 4);
        sbq[dut * 2 + port].push_back(it);
    endtask

    task automatic expect_all(input int port, input logic [DW-1:0] data, input int n);
        expect_rd(0, port, data, 1'b0, n);
        expect_rd(1, port, data, 1'b0, n);
    endtask

    task automatic cyc_drive(input logic ra, input logic wa, input logic [AW-1:0] aa, input logic [DW-1:0] da,
                             input logic rb, input logic wb, input logic [AW-1:0] ab, input logic [DW-1:0] db);
        req_a = ra; we_a = wa; addr_a = aa; wd_a = da;
        req_b = rb; we_b = wb; addr_b = ab; wd_b = db;
        @(posedge clk);
        #1;
        req_a = 1'b0; we_a = 1'b0; req_b = 1'b0; we_b = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc_drive(0, 0, '0, '0, 0, 0, '0, '0);
    endtask

    initial begin
        int n;
        int w;
        rst = 1'b1;
        req_a = 1'b0; we_a = 1'b0; addr_a = '0; wd_a = '0;
        req_b = 1'b0; we_b = 1'b0; addr_b = '0; wd_b = '0;
        for (int i = 0; i < 4; i++) last_exp[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        idle(10);

        @(negedge clk);
        checks++;
        if ({rd3_a, rd3_b, rv3_a, rv3_b, coll3, pe3_a, pe3_b} !== '0) begin
            failures++;
            $display("FAIL reset_idle dut3 got rd_a=%h rd_b=%h rv=%b%b coll=%b pe=%b%b want all 0",
                     rd3_a, rd3_b, rv3_a, rv3_b, coll3, pe3_a, pe3_b);
        end
        checks++;
        if ({rd4_a, rd4_b, rv4_a, rv4_b, coll4, pe4_a, pe4_b} !== '0) begin
            failures++;
            $display("FAIL reset_idle dut4 got rd_a=%h rd_b=%h rv=%b%b coll=%b pe=%b%b want all 0",
                     rd4_a, rd4_b, rv4_a, rv4_b, coll4, pe4_a, pe4_b);
        end
        @(posedge clk);
        #1;

        // Write then dual same-address read.
        cyc_drive(1, 1, 10'h010, 32'hDEADBEEF, 0, 0, '0, '0);
        n = cyc;
        expect_all(0, 32'hDEADBEEF, n);
        expect_all(1, 32'hDEADBEEF, n);
        cyc_drive(1, 0, 10'h010, '0, 1, 0, 10'h010, '0);

        // Double write to the top address: A wins, collision flagged.
        n = cyc;
        collq[0].push_back(n + 1);
        collq[1].push_back(n + 1);
        cyc_drive(1, 1, 10'h3FF, 32'h11111111, 1, 1, 10'h3FF, 32'h22222222);
        n = cyc;
        expect_all(0, 32'h11111111, n);
        expect_all(1, 32'h11111111, n);
        cyc_drive(1, 0, 10'h3FF, '0, 1, 0, 10'h3FF, '0);

        // Read-during-write in both directions.
        cyc_drive(1, 1, 10'h005, 32'hAAAA0000, 1, 1, 10'h006, 32'h12345678);
        n = cyc;
        expect_rd(0, 1, 32'h5555FFFF, 1'b0, n);
        expect_rd(1, 1, 32'hAAAA0000, 1'b0, n);
        cyc_drive(1, 1, 10'h005, 32'h5555FFFF, 1, 0, 10'h005, '0);
        n = cyc;
        expect_rd(0, 0, 32'h0F0F0F0F, 1'b0, n);
        expect_rd(1, 0, 32'h12345678, 1'b0, n);
        cyc_drive(1, 0, 10'h006, '0, 1, 1, 10'h006, 32'h0F0F0F0F);
        n = cyc;
        expect_all(0, 32'h5555FFFF, n);
        expect_all(1, 32'h0F0F0F0F, n);
        cyc_drive(1, 0, 10'h005, '0, 1, 0, 10'h006, '0);

        // Back-to-back reads interrupted by a one-cycle reset.
        cyc_drive(1, 1, 10'h000, 32'h00000100, 1, 1, 10'h002, 32'h00000102);
        cyc_drive(1, 1, 10'h001, 32'h00000101, 1, 1, 10'h003, 32'h00000103);
        n = cyc;
        for (int i = 0; i < 4; i++) begin
            if (i < 3) expect_rd(0, 0, 32'h00000100 + 32'(i), 1'b0, n + i);
            if (i < 2) expect_rd(1, 0, 32'h00000100 + 32'(i), 1'b0, n + i);
            cyc_drive(1, 0, AW'(i), '0, 0, 0, '0, '0);
        end
        idle(1);
        rst = 1'b1;
        cyc_drive(1, 0, 10'h3FF, '0, 1, 1, 10'h010, 32'hBAD0BAD0);
        rst = 1'b0;
        idle(8);

        // Contents survive reset; write during reset was ignored.
        n = cyc;
        expect_all(0, 32'h11111111, n);
        expect_all(1, 32'hDEADBEEF, n);
        cyc_drive(1, 0, 10'h3FF, '0, 1, 0, 10'h010, '0);

`ifdef SRAM_LINE_PARITY_EN
        cyc_drive(1, 1, 10'h020, 32'hC0FFEE00, 1, 1, 10'h021, 32'h12340000);
        dut3.mem[10'h020][5] = ~dut3.mem[10'h020][5];
        dut4.mem[10'h020][5] = ~dut4.mem[10'h020][5];
        n = cyc;
        expect_rd(0, 0, 32'hC0FFEE20, 1'b1, n);
        expect_rd(1, 0, 32'hC0FFEE20, 1'b1, n);
        cyc_drive(1, 0, 10'h020, '0, 0, 0, '0, '0);
        n = cyc;
        expect_rd(0, 0, 32'h12340000, 1'b0, n);
        expect_rd(1, 0, 32'h12340000, 1'b0, n);
        cyc_drive(1, 0, 10'h021, '0, 0, 0, '0, '0);
`endif

        w = 0;
        while ((sbq[0].size() + sbq[1].size() + sbq[2].size() + sbq[3].size() +
                collq[0].size() + collq[1].size()) != 0 && w < 50) begin
            @(posedge clk);
            w++;
        end
        idle(4);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (sbq[i].size() != 0) begin
                failures++;
                $display("FAIL drain stream=%0d pending=%0d want 0", i, sbq[i].size());
            end
        end
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (collq[i].size() != 0) begin
                failures++;
                $display("FAIL drain_collision dut=%0d pending=%0d want 0", i, collq[i].size());
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/generic_sram_line_en_dualport_pipe.md
Name: generic_sram_line_en_dualport_pipe

Overview:
Parametrised true-dual-port line-enabled SRAM with a request/valid handshake per port and a configurable registered read pipeline. Same-address cross-port hazards are resolved in hardware: write-write priority, and read-during-write bypass selectable per instance. It replaces the bare dual-port SRAM wrapper where cache tag/data arrays and DMA buffers need deterministic collision behaviour and retimed read paths.

Parameters:
MEM_ADDR_BITS, 10, address width; depth = 2**MEM_ADDR_BITS lines.
MEM_DATA_BITS, 32, line width in bits.
READ_LATENCY, 1, cycles from read request to o_rvalid_x; legal range 1..4.
BYPASS_EN, 1, 1 = read returns same-cycle cross-port write data (write-first); 0 = returns prior array contents (read-first).

Ports:
i_clk  in  1  clock, all logic on rising edge
i_rst  in  1  synchronous active-high reset
i_req_a  in  1  port A request valid
i_write_en_a  in  1  port A: 1 = line write, 0 = read; sampled with i_req_a
i_addr_a  in  MEM_ADDR_BITS  port A line address
i_write_data_a  in  MEM_DATA_BITS  port A write line
o_read_data_a  out  MEM_DATA_BITS  port A read line, qualified by o_rvalid_a
o_rvalid_a  out  1  port A read data valid, one-cycle pulse per read
i_req_b, i_write_en_b, i_addr_b, i_write_data_b, o_read_data_b, o_rvalid_b  (same as port A, for port B)
o_collision  out  1  one-cycle pulse: both ports wrote the same address in the same cycle
o_parity_err_a  out  1  parity error on port A read (see Optional Feature)
o_parity_err_b  out  1  parity error on port B read

Behaviour:
- Clock is i_clk; reset is synchronous, active-high (i_rst), one clock domain.
- Reset: o_rvalid_a/b = 0, o_read_data_a/b = 0, o_collision = 0, o_parity_err_a/b = 0. All pipeline valid bits cleared. Array contents are not cleared (undefined after power-up, retained across reset).
- No backpressure: a request is accepted every cycle it is asserted. Each port may issue one request per cycle.
- Write: array line updated at the clock edge where i_req_x & i_write_en_x. No o_rvalid_x is generated for writes.
- Read: a read accepted in cycle N asserts o_rvalid_x with data in cycle N+READ_LATENCY. Back-to-back reads produce back-to-back valids in order. Stage 1 is the array read; stages 2..READ_LATENCY are data+valid shift registers.
- o_read_data_x holds its last valid value while o_rvalid_x = 0.
- Write-write collision (both write, i_addr_a == i_addr_b): port A data is stored, port B write is dropped, and o_collision pulses in cycle N+1.
- Read-during-write across ports (same address, same cycle): BYPASS_EN=1 returns the writing port's i_write_data. With a double write, the winning port A data is returned. BYPASS_EN=0 returns the pre-write contents.
- Both ports reading the same address: both return the same data; no collision flagged.
- Read of an address written by either port in an earlier cycle always returns the updated data.
- Reset asserted mid-read: in-flight reads are discarded; no o_rvalid_x pulses for requests issued before or during the reset cycle. Requests are ignored while i_rst = 1.
- Address wrap: none; all 2**MEM_ADDR_BITS addresses are valid. No bounds errors.
- READ_LATENCY outside 1..4: elaboration error via a static assertion.

Optional Feature:
Macro SRAM_LINE_PARITY_EN.
- Defined: the array is MEM_DATA_BITS+1 wide, storing even parity (XOR of the line) on every write. On every read, parity is recomputed and o_parity_err_x pulses aligned with o_rvalid_x on mismatch. Bypassed data is checked against freshly generated parity, so it never errors.
- Not defined: the array is MEM_DATA_BITS wide and o_parity_err_a/b are tied to 0.

Test Plan:
- Reset then idle 10 cycles -> all outputs 0, no rvalid pulses.
- READ_LATENCY=3: A writes 0xDEADBEEF to addr 0x010, then reads it at cycle N -> o_rvalid_a=1 with 0xDEADBEEF exactly at N+3; B reads addr 0x010 in the same cycle -> same data and timing on port B.
- Same cycle, A writes 0x11111111 and B writes 0x22222222 to addr 0x3FF -> o_collision pulses at N+1; a later read of 0x3FF returns 0x11111111.
- Addr 0x005 holds 0xAAAA0000; A writes 0x5555FFFF while B reads 0x005 -> B returns 0x5555FFFF with BYPASS_EN=1, and 0xAAAA0000 with BYPASS_EN=0.
- READ_LATENCY=4: 4 back-to-back A reads of addrs 0..3, then i_rst asserted for 1 cycle after the second rvalid -> exactly 2 rvalids observed, none after reset.
- SRAM_LINE_PARITY_EN defined: force one stored bit flip via hierarchical deposit at addr 0x020, then read -> o_parity_err_a=1 coincident with o_rvalid_a; a clean read at addr 0x021 -> o_parity_err_a=0.
